// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard sequencer for the 5-stage pipeline.
// Ports: ID/EX/MEM register tags, mem handshake and branch in;
//   PC/register pause and nop controls, mem_err, state out.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt, flush_cnt, memwait_cnt.
module pipeline_hazard_ctrl #(
    parameter int FORWARDING   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wr_n,
    input  logic        ex_mem_rd,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_wr_n,
    input  logic        mem_access,
    input  logic        dmem_ready,
    input  logic        ex_branch_taken,
    output logic        pc_pause,
    output logic        if_id_pause,
    output logic        id_ex_pause,
    output logic        ex_mem_pause,
    output logic        if_id_nop,
    output logic        id_ex_nop,
    output logic        ex_mem_nop,
    output logic        mem_wb_nop,
    output logic        mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] memwait_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO         = 8'(MEM_TIMEOUT);

    state_t     st;
    logic [2:0] fcnt;
    logic [7:0] tcnt;

    logic raw_ex, raw_mem, data_stall;
    logic mem_busy, tmo, mem_hold, flush_act, stall_act;

    assign state = st;

    assign raw_ex = !ex_reg_wr_n && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) ||
                     (id_use_rs2 && id_rs2 == ex_rd));
    assign raw_mem = !mem_reg_wr_n && (mem_rd != 5'd0) &&
                     ((id_use_rs1 && id_rs1 == mem_rd) ||
                      (id_use_rs2 && id_rs2 == mem_rd));
    assign data_stall = (FORWARDING != 0) ? (raw_ex && ex_mem_rd)
                                          : (raw_ex || raw_mem);

    // The wait counter only runs while an access is stuck, so tmo can
    // only fire after a held stretch; it drops the access for one cycle.
    assign mem_busy  = mem_access && !dmem_ready;
    assign tmo       = mem_busy && (tcnt >= TMO);
    assign mem_hold  = mem_busy && !tmo;
    assign flush_act = !mem_busy && (ex_branch_taken || st == FLUSH);
    assign stall_act = !mem_busy && !flush_act && data_stall;

    always_comb begin
        pc_pause     = 1'b0;
        if_id_pause  = 1'b0;
        id_ex_pause  = 1'b0;
        ex_mem_pause = 1'b0;
        if_id_nop    = 1'b0;
        id_ex_nop    = 1'b0;
        ex_mem_nop   = 1'b0;
        mem_wb_nop   = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                mem_hold: begin
                    pc_pause     = 1'b1;
                    if_id_pause  = 1'b1;
                    id_ex_pause  = 1'b1;
                    ex_mem_pause = 1'b1;
                    mem_wb_nop   = 1'b1;
                end
                tmo: ex_mem_nop = 1'b1;
                flush_act: begin
                    if_id_nop = 1'b1;
                    id_ex_nop = 1'b1;
                end
                stall_act: begin
                    pc_pause    = 1'b1;
                    if_id_pause = 1'b1;
                    id_ex_nop   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= RUN;
            fcnt    <= 3'd0;
            tcnt    <= 8'd0;
            mem_err <= 1'b0;
        end else if (tmo) begin
            st      <= RUN;
            fcnt    <= 3'd0;
            tcnt    <= 8'd0;
            mem_err <= 1'b1;
        end else if (mem_hold) begin
            // Flush counter freezes; pending branch is replayed on release.
            if (tcnt != 8'hFF)
                tcnt <= tcnt + 8'd1;
            if (st == RUN)
                st <= MEM_WAIT;
        end else begin
            tcnt <= 8'd0;
            if (ex_branch_taken && FLUSH_MULTI) begin
                st   <= FLUSH;
                fcnt <= FLUSH_LOAD;
            end else if (st == FLUSH && fcnt > 3'd1) begin
                fcnt <= fcnt - 3'd1;
            end else begin
                st   <= RUN;
                fcnt <= 3'd0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= 32'd0;
            flush_cnt   <= 32'd0;
            memwait_cnt <= 32'd0;
        end else begin
            if (stall_act)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_act)
                flush_cnt <= flush_cnt + 32'd1;
            if (mem_hold)
                memwait_cnt <= memwait_cnt + 32'd1;
        end
    end
`endif

endmodule
